// File: rtl/snoopy_invalidate_controller.sv
// ==========================================================================
// snoopy_invalidate_controller : MSI snoop-side lookup / flush / state update
// Rev 1.0
// ==========================================================================
`default_nettype none

module snoopy_invalidate_controller #(
  parameter int TAG_WIDTH    = 6,
  parameter int INDEX_WIDTH  = 6,
  parameter int OFFSET_WIDTH = 4,
  parameter int DATA_WIDTH   = 16
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic                                        snoopRequest,
  input  logic [1:0]                                  snoopCommand,
  input  logic [TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH-1:0] snoopAddress,
  output logic                                        snoopAck,
  output logic                                        sharedOut,
  output logic                                        flushValid,
  output logic [DATA_WIDTH-1:0]                       flushData,
  output logic [OFFSET_WIDTH-1:0]                     flushOffset,
  input  logic                                        flushReady,
  output logic [INDEX_WIDTH-1:0]                      snoopyIndex,
  output logic [OFFSET_WIDTH-1:0]                     snoopyOffset,
  output logic [TAG_WIDTH-1:0]                        snoopyTagIn,
  output logic [1:0]                                  snoopyStateIn,
  output logic                                        snoopyWriteState,
  input  logic                                        snoopyHit,
  input  logic [1:0]                                  snoopyStateOut,
  input  logic [DATA_WIDTH-1:0]                       snoopyDataOut
);

  localparam logic [1:0] C_INVALID  = 2'b00;
  localparam logic [1:0] C_SHARED   = 2'b01;
  localparam logic [1:0] C_MODIFIED = 2'b10;
  localparam logic [1:0] C_BUS_READ = 2'd0;
  localparam logic [1:0] C_RESERVED = 2'd3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    FLUSH  = 3'd2,
    UPDATE = 3'd3,
    ACK    = 3'd4
  } state_e;

  state_e                   state_q;
  logic [1:0]               cmd_q;
  logic [TAG_WIDTH-1:0]     tag_q;
  logic [INDEX_WIDTH-1:0]   idx_q;
  logic [OFFSET_WIDTH-1:0]  cnt_q;
  logic                     shared_q;
  logic [1:0]               coh_q;
  logic [1:0]               coh_d;
  logic                     line_valid;
  logic                     unused_offset;

  // The word offset in the snoop address is irrelevant: whole lines are handled.
  assign unused_offset = ^snoopAddress[OFFSET_WIDTH-1:0];

  // Encoding 2'b11 is treated as INVALID, so only S and M count as a present line.
  assign line_valid = snoopyHit &&
                      (snoopyStateOut == C_SHARED || snoopyStateOut == C_MODIFIED);

  always_comb begin
    coh_d = C_INVALID;
    if (cmd_q == C_BUS_READ && line_valid)
      coh_d = C_SHARED;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      tag_q    <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      shared_q <= 1'b0;
      coh_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (snoopRequest) begin
            cmd_q    <= snoopCommand;
            tag_q    <= snoopAddress[TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH-1 -: TAG_WIDTH];
            idx_q    <= snoopAddress[INDEX_WIDTH+OFFSET_WIDTH-1 -: INDEX_WIDTH];
            shared_q <= 1'b0;
            state_q  <= (snoopCommand == C_RESERVED) ? ACK : LOOKUP;
          end
        end
        LOOKUP: begin
          if (!line_valid) begin
            shared_q <= 1'b0;
            state_q  <= ACK;
          end else begin
            shared_q <= 1'b1;
            coh_q    <= coh_d;
            if (snoopyStateOut == C_MODIFIED) begin
              cnt_q   <= '0;
              state_q <= FLUSH;
            end else if (coh_d != snoopyStateOut) begin
              state_q <= UPDATE;
            end else begin
              state_q <= ACK;
            end
          end
        end
        FLUSH: begin
          if (flushReady) begin
            cnt_q <= cnt_q + 1'b1;
            if (&cnt_q)
              state_q <= UPDATE;
          end
        end
        UPDATE:  state_q <= ACK;
        ACK:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign snoopAck         = (state_q == ACK);
  assign sharedOut        = (state_q == ACK) && shared_q;
  assign flushValid       = (state_q == FLUSH);
  assign flushData        = (state_q == FLUSH) ? snoopyDataOut : '0;
  assign flushOffset      = cnt_q;
  assign snoopyOffset     = cnt_q;
  assign snoopyIndex      = idx_q;
  assign snoopyTagIn      = tag_q;
  assign snoopyWriteState = (state_q == UPDATE);
  assign snoopyStateIn    = (state_q == UPDATE) ? coh_q : 2'b00;

endmodule

`default_nettype wire

// File: tb/tb_snoopy_invalidate_controller.sv
// ==========================================================================
// tb_snoopy_invalidate_controller : directed bench with a small cache model
// Rev 1.0
// ==========================================================================
`default_nettype none

module tb_snoopy_invalidate_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        snoopRequest;
  logic [1:0]  snoopCommand;
  logic [15:0] snoopAddress;
  logic        snoopAck, sharedOut, flushValid, flushReady;
  logic [15:0] flushData;
  logic [3:0]  flushOffset, snoopyOffset;
  logic [5:0]  snoopyIndex, snoopyTagIn;
  logic [1:0]  snoopyStateIn, snoopyStateOut;
  logic        snoopyWriteState, snoopyHit;
  logic [15:0] snoopyDataOut;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  snoopy_invalidate_controller #(
    .TAG_WIDTH(6), .INDEX_WIDTH(6), .OFFSET_WIDTH(4), .DATA_WIDTH(16)
  ) dut (
    .clock(clock), .reset(reset),
    .snoopRequest(snoopRequest), .snoopCommand(snoopCommand), .snoopAddress(snoopAddress),
    .snoopAck(snoopAck), .sharedOut(sharedOut),
    .flushValid(flushValid), .flushData(flushData), .flushOffset(flushOffset),
    .flushReady(flushReady),
    .snoopyIndex(snoopyIndex), .snoopyOffset(snoopyOffset), .snoopyTagIn(snoopyTagIn),
    .snoopyStateIn(snoopyStateIn), .snoopyWriteState(snoopyWriteState),
    .snoopyHit(snoopyHit), .snoopyStateOut(snoopyStateOut), .snoopyDataOut(snoopyDataOut)
  );

  // Cache model: per-set tag and state; line data is 0x1000 + index*0x100 + offset.
  logic [1:0] st [64];
  logic [5:0] tg [64];
  logic       clr, pre_en;
  logic [5:0] pre_idx, pre_tag;
  logic [1:0] pre_st;

  always @(posedge clock) begin
    if (clr) begin
      for (int i = 0; i < 64; i++) begin
        st[i] <= 2'b00;
        tg[i] <= 6'd0;
      end
    end else if (pre_en) begin
      st[pre_idx] <= pre_st;
      tg[pre_idx] <= pre_tag;
    end else if (snoopyWriteState) begin
      st[snoopyIndex] <= snoopyStateIn;
    end
  end

  assign snoopyStateOut = st[snoopyIndex];
  assign snoopyHit      = (st[snoopyIndex] == 2'b01 || st[snoopyIndex] == 2'b10) &&
                          (tg[snoopyIndex] == snoopyTagIn);
  assign snoopyDataOut  = 16'h1000 + {2'b00, snoopyIndex, 8'h00} + {12'h000, snoopyOffset};

  task automatic chk(input string t, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", t, got, exp);
    end
  endtask

  task automatic preload(input logic [5:0] idx, input logic [5:0] tag, input logic [1:0] s);
    @(negedge clock);
    pre_en = 1'b1; pre_idx = idx; pre_tag = tag; pre_st = s;
    @(posedge clock);
    #1 pre_en = 1'b0;
  endtask

  int r_ack_cyc, r_ack_cnt, r_wr_cnt, r_wr_cyc, r_fl_cnt, r_fl_err, r_out_err;
  logic       r_shared;
  logic [1:0] r_wr_state;

  // One snoop, observed for a fixed 30-cycle window; cycle 0 is the request-sample cycle.
  task automatic run_snoop(input logic [1:0] cmd, input logic [5:0] tag, input logic [5:0] idx,
                           input int hold, input int stall_at, input int stall_len,
                           input int rst_at);
    int stall_left;
    stall_left = stall_len;
    r_ack_cyc = -1; r_ack_cnt = 0; r_wr_cnt = 0; r_wr_cyc = -1; r_fl_cnt = 0;
    r_fl_err = 0; r_out_err = 0; r_shared = 1'b0; r_wr_state = 2'b11;
    @(negedge clock);
    snoopRequest = 1'b1; snoopCommand = cmd; snoopAddress = {tag, idx, 4'h7};
    @(posedge clock);
    for (int c = 1; c < 30; c++) begin
      @(negedge clock);
      snoopRequest = (c < hold);
      if (c == rst_at) reset = 1'b1;
      if (rst_at > 0 && c == rst_at + 1) begin
        chk("reset_outputs_zero",
            {snoopAck, sharedOut, flushValid, flushData, flushOffset, snoopyIndex,
             snoopyOffset, snoopyTagIn, snoopyStateIn, snoopyWriteState}, 64'd0);
        reset = 1'b0;
      end
      if (r_fl_cnt == stall_at && stall_left > 0) begin
        flushReady = 1'b0;
        stall_left--;
        if (!flushValid || flushData != 16'h1000 + {2'b00, idx, 8'h00} + 16'(r_fl_cnt) ||
            flushOffset != 4'(r_fl_cnt))
          r_fl_err++;
      end else begin
        flushReady = 1'b1;
      end
      if (flushValid && flushReady) begin
        if (flushOffset != 4'(r_fl_cnt) ||
            flushData != 16'h1000 + {2'b00, idx, 8'h00} + 16'(r_fl_cnt))
          r_fl_err++;
        r_fl_cnt++;
      end
      if (snoopAck) begin
        r_ack_cnt++; r_ack_cyc = c; r_shared = sharedOut;
      end else if (sharedOut) r_out_err++;
      if (snoopyWriteState) begin
        r_wr_cnt++; r_wr_cyc = c; r_wr_state = snoopyStateIn;
      end else if (snoopyStateIn != 2'b00) r_out_err++;
    end
  endtask

  initial begin
    reset = 1'b1; clr = 1'b1; pre_en = 1'b0; pre_idx = '0; pre_tag = '0; pre_st = '0;
    snoopRequest = 1'b0; snoopCommand = '0; snoopAddress = '0; flushReady = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_state",
        {snoopAck, sharedOut, flushValid, flushData, flushOffset, snoopyIndex,
         snoopyOffset, snoopyTagIn, snoopyStateIn, snoopyWriteState}, 64'd0);
    reset = 1'b0; clr = 1'b0;

    // Miss
    preload(6'd1, 6'd9, 2'b01);
    run_snoop(2'd0, 6'd5, 6'd1, 1, -1, 0, -1);
    chk("miss_ack_cycle", 64'(r_ack_cyc), 64'd2);
    chk("miss_shared", 64'(r_shared), 64'd0);
    chk("miss_writes_flush", 64'(r_wr_cnt + r_fl_cnt), 64'd0);

    // S hit with BUS_READ: no update
    run_snoop(2'd0, 6'd9, 6'd1, 1, -1, 0, -1);
    chk("s_read_ack_cycle", 64'(r_ack_cyc), 64'd2);
    chk("s_read_shared", 64'(r_shared), 64'd1);
    chk("s_read_no_write", 64'(r_wr_cnt), 64'd0);

    // S hit with BUS_READ_EXCLUSIVE
    run_snoop(2'd1, 6'd9, 6'd1, 1, -1, 0, -1);
    chk("s_rx_write_cycle", 64'(r_wr_cyc), 64'd2);
    chk("s_rx_write_state", 64'(r_wr_state), 64'd0);
    chk("s_rx_ack_cycle", 64'(r_ack_cyc), 64'd3);
    chk("s_rx_shared", 64'(r_shared), 64'd1);
    run_snoop(2'd0, 6'd9, 6'd1, 1, -1, 0, -1);
    chk("s_rx_later_miss", 64'(r_shared), 64'd0);

    // M hit with BUS_READ, no backpressure
    preload(6'd0, 6'd3, 2'b10);
    run_snoop(2'd0, 6'd3, 6'd0, 1, -1, 0, -1);
    chk("m_flush_words", 64'(r_fl_cnt), 64'd16);
    chk("m_flush_data_errs", 64'(r_fl_err), 64'd0);
    chk("m_write_state", 64'(r_wr_state), 64'd1);
    chk("m_write_cycle", 64'(r_wr_cyc), 64'd18);
    chk("m_ack_cycle", 64'(r_ack_cyc), 64'd19);
    chk("m_line_now_shared", 64'(st[0]), 64'd1);

    // M flush with 3 stalled cycles at offset 5
    preload(6'd0, 6'd3, 2'b10);
    run_snoop(2'd0, 6'd3, 6'd0, 1, 5, 3, -1);
    chk("stall_flush_words", 64'(r_fl_cnt), 64'd16);
    chk("stall_data_errs", 64'(r_fl_err), 64'd0);
    chk("stall_ack_cycle", 64'(r_ack_cyc), 64'd22);

    // Reset in the 4th FLUSH cycle
    preload(6'd2, 6'd4, 2'b10);
    run_snoop(2'd2, 6'd4, 6'd2, 1, -1, 0, 5);
    chk("rst_no_write", 64'(r_wr_cnt), 64'd0);
    chk("rst_no_ack", 64'(r_ack_cnt), 64'd0);
    chk("rst_line_still_m", 64'(st[2]), 64'd2);
    run_snoop(2'd1, 6'd4, 6'd2, 1, -1, 0, -1);
    chk("post_rst_ack_cycle", 64'(r_ack_cyc), 64'd19);
    chk("post_rst_flush_ok", {32'(r_fl_cnt), 32'(r_fl_err)}, {32'd16, 32'd0});
    chk("post_rst_state", 64'(st[2]), 64'd0);

    // Reserved command
    run_snoop(2'd3, 6'd4, 6'd2, 1, -1, 0, -1);
    chk("cmd3_ack_cycle", 64'(r_ack_cyc), 64'd1);
    chk("cmd3_shared", 64'(r_shared), 64'd0);

    // Request held high while busy (S line, BUS_INVALIDATE, held until ACK)
    preload(6'd3, 6'd7, 2'b01);
    run_snoop(2'd2, 6'd7, 6'd3, 3, -1, 0, -1);
    chk("held_ack_count", 64'(r_ack_cnt), 64'd1);
    chk("held_write_count", 64'(r_wr_cnt), 64'd1);
    chk("held_ack_cycle", 64'(r_ack_cyc), 64'd3);
    chk("stray_outputs", 64'(r_out_err), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
